// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode encodings, the legal-opcode check and the
// program-loader state encoding.
package isa_pkg;

   localparam int INSTR_W = 9;
   localparam int OPC_W   = 5;

   localparam logic [OPC_W-1:0] OPC_ADD = 5'b00000;
   localparam logic [OPC_W-1:0] OPC_SUB = 5'b00001;
   localparam logic [OPC_W-1:0] OPC_AND = 5'b00010;
   localparam logic [OPC_W-1:0] OPC_OR  = 5'b00011;
   localparam logic [OPC_W-1:0] OPC_XOR = 5'b00100;
   localparam logic [OPC_W-1:0] OPC_SHL = 5'b00101;
   localparam logic [OPC_W-1:0] OPC_SHR = 5'b00110;
   localparam logic [OPC_W-1:0] OPC_LD  = 5'b01000;
   localparam logic [OPC_W-1:0] OPC_ST  = 5'b01001;
   localparam logic [OPC_W-1:0] OPC_JMP = 5'b10000;
   localparam logic [OPC_W-1:0] OPC_BEQ = 5'b10001;
   localparam logic [OPC_W-1:0] OPC_NOP = 5'b11111;

   // The 10010..10101 block is reserved and never decoded by Control.
   function automatic logic is_legal_opc(input logic [OPC_W-1:0] opc);
      return !(opc inside {5'b10010, 5'b10011, 5'b10100, 5'b10101});
   endfunction

   typedef logic [2:0] ld_state_t;
   localparam ld_state_t LD_IDLE   = 3'd0;
   localparam ld_state_t LD_LEN_LO = 3'd1;
   localparam ld_state_t LD_LEN_HI = 3'd2;
   localparam ld_state_t LD_INS_LO = 3'd3;
   localparam ld_state_t LD_INS_HI = 3'd4;
   localparam ld_state_t LD_WRITE  = 3'd5;
   localparam ld_state_t LD_DONE   = 3'd6;

endpackage

// File: rtl/prog_loader.sv
// Loads instruction memory from a byte stream: 16-bit LE count, then one
// byte pair per instruction, with opcode legality and length-overflow flags.
module prog_loader #(
   parameter int INSTR_W = 9,
   parameter int OPC_W   = 5,
   parameter int ADDR_W  = 10
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [INSTR_W-1:0] im_wdat,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   instr_count,
   output logic              err_illegal,
   output logic [ADDR_W-1:0] err_addr,
   output logic              err_len
);
   import isa_pkg::*;

   localparam int HI_W = INSTR_W - 8;
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   ld_state_t            state_q;
   logic [15:0]          len_q;
   logic [15:0]          rcv_q;
   logic [7:0]           lo_q;
   logic [INSTR_W-1:0]   instr_q;
   // MSB set means the counter has saturated at DEPTH: further writes are dropped.
   logic [ADDR_W:0]      addr_q;
   logic                 accept;
   logic                 write_en;
   logic [15:0]          len_next;

   assign byte_ready = (state_q == LD_LEN_LO) || (state_q == LD_LEN_HI) ||
                       (state_q == LD_INS_LO) || (state_q == LD_INS_HI);
   assign accept     = byte_valid && byte_ready;
   assign write_en   = (state_q == LD_WRITE) && !addr_q[ADDR_W];
   assign len_next   = {byte_data, len_q[7:0]};

   assign im_we       = write_en;
   assign im_addr     = addr_q[ADDR_W-1:0];
   assign im_wdat     = instr_q;
   assign instr_count = addr_q;
   assign busy        = (state_q != LD_IDLE) && (state_q != LD_DONE);
   assign done        = (state_q == LD_DONE);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= LD_IDLE;
         len_q       <= '0;
         rcv_q       <= '0;
         lo_q        <= '0;
         instr_q     <= '0;
         addr_q      <= '0;
         err_illegal <= 1'b0;
         err_addr    <= '0;
         err_len     <= 1'b0;
      end else begin
         case (state_q)
            LD_IDLE, LD_DONE: begin
               if (start) begin
                  state_q     <= LD_LEN_LO;
                  rcv_q       <= '0;
                  addr_q      <= '0;
                  err_illegal <= 1'b0;
                  err_addr    <= '0;
                  err_len     <= 1'b0;
               end
            end
            LD_LEN_LO: begin
               if (accept) begin
                  len_q[7:0] <= byte_data;
                  state_q    <= LD_LEN_HI;
               end
            end
            LD_LEN_HI: begin
               if (accept) begin
                  len_q[15:8] <= byte_data;
                  if (32'(len_next) > DEPTH) err_len <= 1'b1;
                  state_q <= (len_next == 16'd0) ? LD_DONE : LD_INS_LO;
               end
            end
            LD_INS_LO: begin
               if (accept) begin
                  lo_q    <= byte_data;
                  state_q <= LD_INS_HI;
               end
            end
            LD_INS_HI: begin
               if (accept) begin
                  instr_q <= {byte_data[HI_W-1:0], lo_q};
                  state_q <= LD_WRITE;
               end
            end
            LD_WRITE: begin
               rcv_q <= rcv_q + 16'd1;
               if (!addr_q[ADDR_W]) addr_q <= addr_q + 1'b1;
               if (write_en && !is_legal_opc(instr_q[INSTR_W-1 -: OPC_W])) begin
                  err_illegal <= 1'b1;
                  if (!err_illegal) err_addr <= addr_q[ADDR_W-1:0];
               end
               state_q <= ((rcv_q + 16'd1) == len_q) ? LD_DONE : LD_INS_LO;
            end
            default: state_q <= LD_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader using a small address space so the
// length-overflow path is reachable.
module tb_prog_loader;

   localparam int AW = 2;

   logic          Clk = 1'b0;
   logic          Reset = 1'b0;
   logic          start = 1'b0;
   logic          byte_valid = 1'b0;
   logic [7:0]    byte_data = '0;
   logic          byte_ready;
   logic          im_we;
   logic [AW-1:0] im_addr;
   logic [8:0]    im_wdat;
   logic          busy;
   logic          done;
   logic [AW:0]   instr_count;
   logic          err_illegal;
   logic [AW-1:0] err_addr;
   logic          err_len;

   always #5 Clk = ~Clk;

   prog_loader #(.INSTR_W(9), .OPC_W(5), .ADDR_W(AW)) dut (
      .Clk(Clk), .Reset(Reset), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready), .im_we(im_we),
      .im_addr(im_addr), .im_wdat(im_wdat), .busy(busy), .done(done),
      .instr_count(instr_count), .err_illegal(err_illegal),
      .err_addr(err_addr), .err_len(err_len)
   );

   typedef struct packed {
      int              nb;
      logic [15:0][7:0] b;
      int              nw;
      logic [7:0][1:0] wa;
      logic [7:0][8:0] wd;
      logic [2:0]      cnt;
      logic            ill;
      logic [1:0]      eaddr;
      logic            elen;
      int              gap;
      int              mid_start;
   } vec_t;

   vec_t v [5];
   int total = 0;
   int bad = 0;
   logic [1:0] qa [$];
   logic [8:0] qd [$];

   always @(negedge Clk) begin
      if (im_we) begin
         qa.push_back(im_addr);
         qd.push_back(im_wdat);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic nv(input int k, input int gap, input int ms, input logic [2:0] cnt,
                     input logic ill, input logic [1:0] ea, input logic elen);
      v[k] = '0;
      v[k].gap = gap; v[k].mid_start = ms; v[k].cnt = cnt;
      v[k].ill = ill; v[k].eaddr = ea; v[k].elen = elen;
   endtask

   task automatic pb(input int k, input logic [7:0] x);
      v[k].b[v[k].nb] = x;
      v[k].nb++;
   endtask

   task automatic pw(input int k, input logic [1:0] a, input logic [8:0] d);
      v[k].wa[v[k].nw] = a;
      v[k].wd[v[k].nw] = d;
      v[k].nw++;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
   endtask

   // Called on a negedge; returns on the negedge after the byte is taken.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      if (gap > 0)
         for (int k = 0; k < 8 && $urandom_range(99) < gap; k++) @(negedge Clk);
      byte_valid = 1'b1;
      byte_data  = b;
      n = 0;
      while (!byte_ready && n < 50) begin
         @(negedge Clk);
         n++;
      end
      chk("byte_accept", 32'(byte_ready), 32'd1);
      if (byte_ready) @(negedge Clk);
      byte_valid = 1'b0;
   endtask

   task automatic run_vec(input int k);
      int n;
      pulse_start();
      qa.delete();
      qd.delete();
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_done_clr", 32'(done), 32'd0);
      chk("start_cnt_clr", 32'(instr_count), 32'd0);
      chk("start_ill_clr", 32'(err_illegal), 32'd0);
      chk("start_len_clr", 32'(err_len), 32'd0);
      for (int j = 0; j < v[k].nb; j++) begin
         if (j == v[k].mid_start) begin
            pulse_start();
            chk("mid_start_ignored", 32'(busy), 32'd1);
         end
         send_byte(v[k].b[j], v[k].gap);
      end
      if (v[k].cnt == 3'd0) chk("zero_len_done_edge", 32'(done), 32'd1);
      n = 0;
      while (!done && n < 40) begin
         @(negedge Clk);
         n++;
      end
      chk("done", 32'(done), 32'd1);
      chk("num_writes", 32'(qa.size()), 32'(v[k].nw));
      for (int i = 0; i < v[k].nw && i < qa.size(); i++) begin
         chk($sformatf("v%0d_addr%0d", k, i), 32'(qa[i]), 32'(v[k].wa[i]));
         chk($sformatf("v%0d_data%0d", k, i), 32'(qd[i]), 32'(v[k].wd[i]));
      end
      chk("instr_count", 32'(instr_count), 32'(v[k].cnt));
      chk("err_illegal", 32'(err_illegal), 32'(v[k].ill));
      chk("err_addr", 32'(err_addr), 32'(v[k].eaddr));
      chk("err_len", 32'(err_len), 32'(v[k].elen));
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_ready", 32'(byte_ready), 32'd0);
      @(negedge Clk);
      chk("done_held", 32'(done), 32'd1);
   endtask

   initial begin
      // basic load
      nv(0, 0, -1, 3'd3, 1'b0, 2'd0, 1'b0);
      pb(0, 8'h03); pb(0, 8'h00); pb(0, 8'hC5); pb(0, 8'h00);
      pb(0, 8'hF0); pb(0, 8'h01); pb(0, 8'h00); pb(0, 8'h00);
      pw(0, 2'd0, 9'h0C5); pw(0, 2'd1, 9'h1F0); pw(0, 2'd2, 9'h000);
      // zero length
      nv(1, 0, -1, 3'd0, 1'b0, 2'd0, 1'b0);
      pb(1, 8'h00); pb(1, 8'h00);
      // illegal opcodes at addr 1 and 2; first one is recorded
      nv(2, 0, -1, 3'd3, 1'b1, 2'd1, 1'b0);
      pb(2, 8'h03); pb(2, 8'h00); pb(2, 8'h10); pb(2, 8'h00);
      pb(2, 8'h25); pb(2, 8'h01); pb(2, 8'h40); pb(2, 8'h01);
      pw(2, 2'd0, 9'h010); pw(2, 2'd1, 9'h125); pw(2, 2'd2, 9'h140);
      // basic stream under 50% backpressure with a stray start mid-load
      nv(3, 50, 4, 3'd3, 1'b0, 2'd0, 1'b0);
      for (int j = 0; j < v[0].nb; j++) pb(3, v[0].b[j]);
      pw(3, 2'd0, 9'h0C5); pw(3, 2'd1, 9'h1F0); pw(3, 2'd2, 9'h000);
      // overflow: L=6 into depth 4; unwritten illegal pair must not flag
      nv(4, 0, -1, 3'd4, 1'b0, 2'd0, 1'b1);
      pb(4, 8'h06); pb(4, 8'h00); pb(4, 8'h01); pb(4, 8'h00);
      pb(4, 8'h02); pb(4, 8'hFE); pb(4, 8'h03); pb(4, 8'hFF);
      pb(4, 8'h04); pb(4, 8'h00); pb(4, 8'h25); pb(4, 8'h01);
      pb(4, 8'h06); pb(4, 8'h00);
      pw(4, 2'd0, 9'h001); pw(4, 2'd1, 9'h002); pw(4, 2'd2, 9'h103); pw(4, 2'd3, 9'h004);

      // reset held two cycles with start asserted
      @(negedge Clk);
      Reset = 1'b1;
      start = 1'b1;
      repeat (2) @(negedge Clk);
      chk("rst_ready", 32'(byte_ready), 32'd0);
      chk("rst_we", 32'(im_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cnt", 32'(instr_count), 32'd0);
      chk("rst_addr", 32'(im_addr), 32'd0);
      chk("rst_wdat", 32'(im_wdat), 32'd0);
      chk("rst_errs", 32'({err_illegal, err_len, err_addr}), 32'd0);
      Reset = 1'b0;
      start = 1'b0;
      @(negedge Clk);
      chk("rst_stays_idle", 32'(busy), 32'd0);

      for (int k = 0; k < 5; k++) run_vec(k);

      // reset after two writes with a half-received third pair
      pulse_start();
      qa.delete();
      qd.delete();
      for (int j = 0; j < 7; j++) send_byte(v[0].b[j], 0);
      Reset = 1'b1;
      @(negedge Clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_we", 32'(im_we), 32'd0);
      chk("midrst_ready", 32'(byte_ready), 32'd0);
      chk("midrst_cnt", 32'(instr_count), 32'd0);
      Reset = 1'b0;
      @(negedge Clk);
      chk("midrst_writes", 32'(qa.size()), 32'd2);
      run_vec(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Fills instruction memory from an external byte stream before the core runs.
- Handles the writer side of the instruction store; the control decoder reads opcodes out of that store.
- Assembles 9-bit instructions (opcode = bits [8:4]) from byte pairs and writes them at sequential addresses.
- Checks every opcode against the ISA's legal set and records the first illegal one.

Parameters:
- INSTR_W, 9, instruction width.
- OPC_W, 5, opcode width; opcode occupies instr[INSTR_W-1 -: OPC_W].
- ADDR_W, 10, instruction-memory address width; depth = 2**ADDR_W.

Ports:
- Clk  in  1  clock; all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  begin a load; honoured only in IDLE or DONE.
- byte_valid  in  1  source has a byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte this cycle.
- im_we  out  1  instruction-memory write strobe.
- im_addr  out  ADDR_W  write address.
- im_wdat  out  INSTR_W  write data.
- busy  out  1  load in progress (not IDLE/DONE).
- done  out  1  load complete; level, held until next start.
- instr_count  out  ADDR_W+1  instructions written this load.
- err_illegal  out  1  sticky: some written instruction had an illegal opcode.
- err_addr  out  ADDR_W  address of the first illegal instruction.
- err_len  out  1  sticky: declared length exceeded depth.

Behaviour:
- Interface: one clock (Clk); Reset is synchronous and active-high. With Reset high at a rising edge the block enters IDLE and all outputs go to 0, including byte_ready, im_we, busy, done, counters and error flags.
- Byte transfer: occurs on an edge where byte_valid && byte_ready. byte_ready is a function of state only, never of byte_valid.
- Stream format:
  - LEN_LO and LEN_HI give a 16-bit little-endian instruction count L.
  - Then L byte pairs: the low byte is instr[7:0]; bit 0 of the high byte is instr[8]. High-byte bits [7:1] are ignored.
- States:
  - IDLE: byte_ready=0. On start go to LEN_LO and clear the error flags, instr_count and the address counter.
  - LEN_LO: byte_ready=1. On accept, latch L[7:0] and go to LEN_HI.
  - LEN_HI: byte_ready=1. On accept, latch L[15:8]. If L==0 go to DONE; otherwise go to INS_LO.
  - INS_LO: byte_ready=1. On accept, latch the low byte and go to INS_HI.
  - INS_HI: byte_ready=1. On accept, form the instruction and go to WRITE.
  - WRITE: byte_ready=0.
    - im_we=1 for exactly this cycle, with im_addr = current address and im_wdat = the assembled instruction.
    - Next edge: address+1 and received+1. If received+1 == L go to DONE; otherwise go to INS_LO.
  - DONE: done=1, byte_ready=0. start returns to LEN_LO, clearing flags and counters.
- Throughput: minimum 3 cycles per instruction. Gaps in byte_valid only stall; no data is lost or duplicated.
- Opcode check:
  - Legal: every 5-bit code except 5'b10010, 10011, 10100, 10101.
  - An illegal instruction is still written.
  - err_illegal is set at the WRITE cycle. err_addr captures the address only when err_illegal was previously 0.
- Length overflow:
  - If L > 2**ADDR_W, err_len is set in LEN_HI.
  - All L pairs are still consumed, but im_we is suppressed once the address counter has wrapped past depth-1.
  - instr_count saturates at 2**ADDR_W.
  - The illegal-opcode check applies only to written instructions.
- start while busy: ignored.
- Reset mid-load: returns to IDLE immediately, im_we drops the same edge, and any partial byte pair is discarded. Memory contents already written remain; there is no rollback.
- busy = state not in {IDLE, DONE}. instr_count equals the number of im_we pulses this load.

Decomposition:
- Shared package isa_pkg holds:
  - OPC_W, INSTR_W;
  - opcode localparams (ADD … NOP), the same set Control uses;
  - function is_legal_opc(opc);
  - loader state enum.
- No sub-module. The legal check is the package function; Control and the assembler tests reuse it.

Test Plan:
- Reset: hold Reset 2 cycles -> all outputs 0, byte_ready=0, state IDLE; start held during Reset is ignored.
- Basic load: start; bytes 03,00, C5,00, F0,01, 00,00 -> three im_we pulses at addr 0,1,2 with data 0x0C5, 0x1F0, 0x000; done=1, instr_count=3, no error flags.
- Zero length: start; bytes 00,00 -> no im_we, done=1 the edge after LEN_HI accept, instr_count=0.
- Illegal opcode: L=3 with instructions 0x010, 0x125 (opc 10010), 0x140 (opc 10100) -> all 3 written; err_illegal=1, err_addr=1 (not 2).
- Backpressure and restart:
  - Same stream as basic load with byte_valid random 50% -> identical writes.
  - start pulsed mid-load -> ignored.
  - Reset after 2 writes, then a new load -> writes restart at addr 0.
- Overflow (ADDR_W=2): L=6 -> err_len=1, writes at addr 0–3 only, all 12 payload bytes accepted, instr_count=4, done=1.
